hub_host_master: RTL and testbench
==================================

# hub_host_master

Hub-bus initiator that lets an external host (debugger or loader) read and write hub memory. It occupies one otherwise-unused cog slot on the shared hub bus. It accepts one host command at a time and waits for its one-hot `bus_sel` slot. During that slot it drives a request onto the OR-combined hub bus, then returns read data or completion to the host. It is the initiator counterpart of the hub responder and is instantiated in `dig` in place of an absent cog.

## Interface
Parameters:
- `TIMEOUT`, 64: clock cycles allowed from request launch to `bus_ack` before the command completes with an error.

Ports:
- `clk_cog` in 1: cog clock; all logic on its rising edge.
- `res` in 1: asynchronous, active-high reset.
- `ena_bus` in 1: hub bus phase enable; toggles every clock.
- `bus_sel` in 1: this slot's one-hot select from the hub rotator.
- `bus_r` out 1: bus request; OR-combined with the other slots.
- `bus_e` out 1: hub-op execute; always 0 (hub ops are not supported).
- `bus_w` out 1: write strobe.
- `bus_s` out 2: access size. 00 = byte, 01 = word, 10 = long.
- `bus_a` out 16: hub byte address.
- `bus_d` out 32: write data, lane-replicated.
- `bus_q` in 32: hub read data, as an aligned long.
- `bus_ack` in 1: hub acknowledge for this slot.
- `host_req` in 1: command valid.
- `host_we` in 1: 1 = write.
- `host_size` in 2: encoded as for `bus_s`.
- `host_addr` in 16: byte address.
- `host_wdata` in 32: write data, right-justified.
- `host_busy` out 1: a command is in flight; `host_req` is ignored while it is high.
- `host_done` out 1: one-cycle completion pulse.
- `host_err` out 1: valid only with `host_done`.
- `host_rdata` out 32: zero-extended read data; valid from `host_done` until the next accept.

## Operation
- **Reset (async):**
  - State goes to IDLE.
  - `host_busy`, `host_done`, `host_err` = 0.
  - `host_rdata` = 0.
  - All bus outputs = 0.
- **Bus outputs when not requesting:** all bus outputs are 0 unless state is REQ and `bus_sel` = 1. They are gated combinationally by `bus_sel` from registered payload, because the bus is a wired OR.
- **FSM states:**
  - **IDLE:** on `host_req`, latch the command and set `host_busy`.
    - If misaligned (word with `addr[0]`, long with `addr[1:0]` ≠ 0, or size 11), go to DONE with err = 1. No bus activity occurs.
    - Otherwise go to REQ.
  - **REQ:** drive `bus_r` = 1, `bus_w` = we, size, address and data while `bus_sel` is high. Timeout counter runs. On a clock edge with `bus_ack` = 1, capture the read lane and go to DONE with err = 0.
  - **DONE:** pulse `host_done` for one cycle, clear `host_busy`, return to IDLE.
- **Timeout:** the counter reaches `TIMEOUT` in REQ. `bus_r` is dropped, state goes to DONE with err = 1, and `host_rdata` is unchanged.
- **Write data replication:**
  - byte: `{4{wdata[7:0]}}`
  - word: `{2{wdata[15:0]}}`
  - long: as-is
- **Read lane extraction:**
  - byte: `bus_q >> (8 * addr[1:0])`, masked to 8 bits.
  - word: `bus_q >> (16 * addr[1])`, masked to 16 bits.
- **Boundary cases:**
  - Address wrap: `0xFFFF` byte access is legal; no carry.
  - `bus_ack` arriving while `bus_sel` is low is ignored.
  - `host_req` during busy is dropped (not queued).
  - A new `host_req` in the DONE cycle is ignored. It is accepted from the IDLE cycle on.
  - `res` mid-REQ drops `bus_r` immediately; no `host_done` is produced.

## Timing
- Accept is one cycle: a `host_req` sampled in IDLE raises `host_busy` on the next edge.
- Slot wait is 0–14 cycles with 8 slots at 2 cycles each.
- Nominal latency from `host_req` edge to `host_done`: 3 cycles if the slot is already active, 17 worst case.
- A misaligned command produces `host_done` + `host_err` 2 cycles after accept.
- `host_rdata` updates on the same edge that `host_done` rises.

## Structure
- Shared package (`hub_pkg`) holds:
  - size encodings `SZ_BYTE` / `SZ_WORD` / `SZ_LONG`;
  - hub address width 16 and data width 32;
  - FSM state typedef.
- One sub-module, `hub_lane`: combinational write replication and read extraction, driven by size and `addr[1:0]`. It is reusable by cogs.
- Target is about 180 lines of RTL.

## Test plan
- Long write `0x0100` ← `0xDEADBEEF`, ack in slot → `bus_r`/`bus_w`/`bus_s` = 10, `bus_d` = `DEADBEEF` only while `bus_sel`; `host_done`, err = 0.
- Byte read `0x0103`, `bus_q` = `0x11223344` → `host_rdata` = `0x00000011`.
- Word read `0x0102`, `bus_q` = `0xAABBCCDD` → `host_rdata` = `0x0000AABB`.
- Misaligned long `0x0102` → `host_done` + `host_err` 2 cycles after accept, and `bus_r` never asserts.
- Hub never acks, `TIMEOUT` = 64 → `host_err` after 64 REQ cycles, `bus_r` low afterward.
- Assert `res` mid-REQ with `bus_sel` high → all outputs 0 asynchronously; a subsequent command completes normally.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared definitions for hub bus initiators and responders.
//   HUB_AW / HUB_DW : hub byte-address width and data width
//   SZ_BYTE / SZ_WORD / SZ_LONG : access size encodings (bus_s / host_size)
//   hub_state_t     : command FSM states of the host master
//   is_misaligned() : true when a size/address pair cannot go on the bus
package hub_pkg;

    localparam int HUB_AW = 16;
    localparam int HUB_DW = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } hub_state_t;

    // Encoding 11 has no meaning on the bus, so it is treated like a
    // misaligned access and rejected before any bus activity.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_WORD: return addr_lo[0];
            SZ_LONG: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/hub_lane.sv
// Byte-lane steering between a right-justified host value and the hub's
// aligned 32-bit long. Purely combinational.
//   size       : access size (SZ_BYTE / SZ_WORD / SZ_LONG)
//   addr_lo    : low two address bits selecting the lane
//   wdata      : right-justified write data
//   wdata_rep  : write data replicated across all lanes of its size
//   rdata_long : aligned long returned by the hub
//   rdata_ext  : selected lane, zero-extended
module hub_lane
    import hub_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [HUB_DW-1:0] wdata,
    output logic [HUB_DW-1:0] wdata_rep,
    input  logic [HUB_DW-1:0] rdata_long,
    output logic [HUB_DW-1:0] rdata_ext
);

    // Replicating the write value lets the responder pick whichever lane
    // the address points at without needing a shifter of its own.
    always_comb begin
        wdata_rep = wdata;
        rdata_ext = rdata_long;
        case (size)
            SZ_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h000000, rdata_long[{addr_lo, 3'b000} +: 8]};
            end
            SZ_WORD: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0000, rdata_long[{addr_lo[1], 4'b0000} +: 16]};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = rdata_long;
            end
        endcase
    end

endmodule

// File: rtl/hub_host_master.sv
// Hub bus initiator giving an external host read/write access to hub
// memory from an otherwise unused cog slot. One command at a time: the
// command is latched, the request is driven during this slot's bus_sel,
// and completion (with read data or an error) is returned as a one-cycle
// host_done pulse.
//   clk_cog, res      : clock and asynchronous active-high reset
//   ena_bus, bus_sel  : hub phase enable and this slot's one-hot select
//   bus_r/e/w/s/a/d   : request outputs, zero outside an active slot (wired OR)
//   bus_q, bus_ack    : hub read long and acknowledge
//   host_req/we/size/addr/wdata : host command
//   host_busy/done/err/rdata    : host status and read data
module hub_host_master
    import hub_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk_cog,
    input  logic              res,
    input  logic              ena_bus,
    input  logic              bus_sel,
    output logic              bus_r,
    output logic              bus_e,
    output logic              bus_w,
    output logic [1:0]        bus_s,
    output logic [HUB_AW-1:0] bus_a,
    output logic [HUB_DW-1:0] bus_d,
    input  logic [HUB_DW-1:0] bus_q,
    input  logic              bus_ack,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [1:0]        host_size,
    input  logic [HUB_AW-1:0] host_addr,
    input  logic [HUB_DW-1:0] host_wdata,
    output logic              host_busy,
    output logic              host_done,
    output logic              host_err,
    output logic [HUB_DW-1:0] host_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    hub_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [HUB_AW-1:0] addr_q, addr_d;
    logic [HUB_DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_next;
    logic              err_q, err_d;
    logic [HUB_DW-1:0] cap_q, cap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              herr_q, herr_d;
    logic [HUB_DW-1:0] rdata_q, rdata_d;

    logic [HUB_DW-1:0] wdata_rep;
    logic [HUB_DW-1:0] rdata_ext;
    logic              bus_active;

    // bus_sel alone marks the slot, so the phase enable carries no extra
    // information for this initiator.
    logic unused_ena_bus;
    assign unused_ena_bus = ena_bus;

    hub_lane u_lane (
        .size       (size_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .wdata_rep  (wdata_rep),
        .rdata_long (bus_q),
        .rdata_ext  (rdata_ext)
    );

    // Bus outputs are gated combinationally by bus_sel so that nothing but
    // zeros reaches the OR-combined bus outside this slot, and so that a
    // reset removes the request at once.
    assign bus_active = (state_q == ST_REQ) && bus_sel;
    assign bus_r      = bus_active;
    assign bus_e      = 1'b0;
    assign bus_w      = bus_active && we_q;
    assign bus_s      = bus_active ? size_q    : 2'b00;
    assign bus_a      = bus_active ? addr_q    : '0;
    assign bus_d      = bus_active ? wdata_rep : '0;

    assign host_busy  = busy_q;
    assign host_done  = done_q;
    assign host_err   = herr_q;
    assign host_rdata = rdata_q;

    // Command FSM. Read data is captured into cap_q on the acknowledge edge
    // and only moved to host_rdata when host_done is raised, so the host
    // sees data and completion change together. An ack outside the slot is
    // ignored because the request is not on the bus then.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        cnt_next = cnt_q + 1'b1;
        err_d    = err_q;
        cap_d    = cap_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        herr_d   = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    we_d    = host_we;
                    size_d  = host_size;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (is_misaligned(host_size, host_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus_sel && bus_ack) begin
                    cap_d   = rdata_ext;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_next == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                herr_d  = err_q;
                busy_d  = 1'b0;
                if (!err_q && !we_q) begin
                    rdata_d = cap_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            herr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            herr_q  <= herr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_hub_host_master.sv
// Self-checking bench for hub_host_master. A byte-addressed reference
// memory predicts every completion; expectations are queued at issue time
// and a monitor pops them whenever host_done appears. A hub model rotates
// bus_sel, answers requests from its own memory and throws stray acks
// outside the slot.
module tb_hub_host_master;
    import hub_pkg::*;

    localparam int         TIMEOUT = 64;
    localparam logic [2:0] MY_SLOT = 3'd5;

    logic        clk_cog;
    logic        res;
    logic        ena_bus;
    logic        bus_sel;
    logic        bus_r;
    logic        bus_e;
    logic        bus_w;
    logic [1:0]  bus_s;
    logic [15:0] bus_a;
    logic [31:0] bus_d;
    logic [31:0] bus_q;
    logic        bus_ack;
    logic        host_req;
    logic        host_we;
    logic [1:0]  host_size;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_busy;
    logic        host_done;
    logic        host_err;
    logic [31:0] host_rdata;

    typedef struct {
        bit          chk_rd;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [65536];
    logic [7:0]  hub_mem [65536];
    logic [3:0]  phase = 4'd0;
    bit          ack_on = 1'b1;
    bit          cur_bus_ok = 1'b0;
    logic        cur_we = 1'b0;
    logic [1:0]  cur_size = 2'b00;
    logic [15:0] cur_addr = 16'h0000;
    logic [31:0] cur_d = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;

    hub_host_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk_cog    (clk_cog),
        .res        (res),
        .ena_bus    (ena_bus),
        .bus_sel    (bus_sel),
        .bus_r      (bus_r),
        .bus_e      (bus_e),
        .bus_w      (bus_w),
        .bus_s      (bus_s),
        .bus_a      (bus_a),
        .bus_d      (bus_d),
        .bus_q      (bus_q),
        .bus_ack    (bus_ack),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_size  (host_size),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_busy  (host_busy),
        .host_done  (host_done),
        .host_err   (host_err),
        .host_rdata (host_rdata)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic bit ref_misaligned(input logic [1:0] size, input logic [15:0] addr);
        int a;
        a = int'(addr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int ref_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [31:0] ref_read(input logic [15:0] addr, input logic [1:0] size);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < ref_bytes(size); i++)
            v = v | (32'(ref_mem[addr + 16'(i)]) << (8 * i));
        return v;
    endfunction

    task automatic ref_write(input logic [15:0] addr, input logic [1:0] size, input logic [31:0] w);
        for (int i = 0; i < ref_bytes(size); i++)
            ref_mem[addr + 16'(i)] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] rep(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Slot rotator: 8 slots of 2 cycles, inputs changed just after the edge.
    initial begin
        bus_sel = 1'b0;
        ena_bus = 1'b0;
        forever begin
            @(posedge clk_cog);
            #1;
            phase   = phase + 4'd1;
            bus_sel = (phase[3:1] == MY_SLOT);
            ena_bus = phase[0];
        end
    end

    // Hub responder: acks in the first or second slot cycle, writes land in
    // hub_mem from the lane the address selects, stray acks outside the slot.
    initial begin
        logic [15:0] a4;
        logic [15:0] hub_a;
        bus_ack = 1'b0;
        bus_q   = 32'h0;
        forever begin
            @(negedge clk_cog);
            if (bus_r && bus_sel && ack_on && (phase[0] || ($urandom_range(1) == 1))) begin
                a4      = {bus_a[15:2], 2'b00};
                bus_q   = {hub_mem[a4 + 16'd3], hub_mem[a4 + 16'd2],
                           hub_mem[a4 + 16'd1], hub_mem[a4]};
                bus_ack = 1'b1;
                if (bus_w) begin
                    for (int i = 0; i < ref_bytes(bus_s); i++) begin
                        hub_a          = bus_a + 16'(i);
                        hub_mem[hub_a] = bus_d[8*hub_a[1:0] +: 8];
                    end
                end
            end else if (!bus_sel) begin
                bus_ack = ($urandom_range(1) == 1);
                bus_q   = $urandom;
            end else begin
                bus_ack = 1'b0;
                bus_q   = $urandom;
            end
        end
    end

    // Monitor: bus payload while requesting, quiet bus otherwise, and
    // scoreboard comparison on every host_done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_cog);
            if (!res) begin
                checkOutput("bus_e", {31'b0, bus_e}, 32'h0);
                if (bus_r) begin
                    checkOutput("bus_r_allowed", 32'h1, {31'b0, bus_sel && cur_bus_ok});
                    checkOutput("bus_w", {31'b0, bus_w}, {31'b0, cur_we});
                    checkOutput("bus_s", {30'b0, bus_s}, {30'b0, cur_size});
                    checkOutput("bus_a", {16'b0, bus_a}, {16'b0, cur_addr});
                    checkOutput("bus_d", bus_d, cur_d);
                end else begin
                    checkOutput("bus_idle", {31'b0, |{bus_w, bus_s, bus_a, bus_d}}, 32'h0);
                end
                if (host_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got host_done=1, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("host_err", {31'b0, host_err}, {31'b0, e.err});
                        checkOutput("busy_at_done", {31'b0, host_busy}, 32'h0);
                        if (e.chk_rd) checkOutput("host_rdata", host_rdata, e.rdata);
                        cur_bus_ok = 1'b0;
                    end
                end
            end
        end
    end

    // Issues one command, optionally pulsing junk requests while busy, and
    // returns the number of edges from accept to host_done.
    task automatic applyStimulus(input logic we, input logic [1:0] size,
                                 input logic [15:0] addr, input logic [31:0] wdata,
                                 input bit junk, input bit expect_timeout,
                                 output int lat);
        exp_t e;
        bit   mis;
        int   n;
        n = 0;
        while (host_busy && n < 200) begin
            @(posedge clk_cog);
            #1;
            n++;
        end
        mis      = ref_misaligned(size, addr);
        e.err    = mis || expect_timeout;
        e.chk_rd = (!we && !mis) || expect_timeout;
        e.rdata  = last_rdata;
        if (!mis && !expect_timeout) begin
            if (we) ref_write(addr, size, wdata);
            else begin
                e.rdata    = ref_read(addr, size);
                last_rdata = e.rdata;
            end
        end
        cur_we     = we;
        cur_size   = size;
        cur_addr   = addr;
        cur_d      = rep(size, wdata);
        cur_bus_ok = !mis;
        exp_q.push_back(e);

        host_req   = 1'b1;
        host_we    = we;
        host_size  = size;
        host_addr  = addr;
        host_wdata = wdata;
        @(posedge clk_cog);
        #1;
        checkOutput("accept_busy", {31'b0, host_busy}, 32'h1);
        host_req = 1'b0;

        n = 0;
        while (!host_done && n < TIMEOUT + 40) begin
            if (junk && host_busy && $urandom_range(3) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom);
                host_size  = 2'($urandom);
                host_addr  = 16'($urandom);
                host_wdata = $urandom;
            end else begin
                host_req = 1'b0;
            end
            @(posedge clk_cog);
            #1;
            n++;
        end
        host_req = 1'b0;
        lat = n;
        if (!host_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_wait: got no host_done in %0d cycles, expected completion", n);
            exp_q.delete();
            cur_bus_ok = 1'b0;
        end
        @(negedge clk_cog);
        #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got no end of run, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int          lat;
        int          n;
        logic [1:0]  sz;
        logic [15:0] a;
        res        = 1'b1;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_size  = 2'b00;
        host_addr  = 16'h0;
        host_wdata = 32'h0;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = 8'($urandom);
            hub_mem[i] = ref_mem[i];
        end
        #3;
        checkOutput("reset_busy", {31'b0, host_busy}, 32'h0);
        checkOutput("reset_done", {31'b0, host_done}, 32'h0);
        checkOutput("reset_err", {31'b0, host_err}, 32'h0);
        checkOutput("reset_rdata", host_rdata, 32'h0);
        checkOutput("reset_bus", {31'b0, |{bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}}, 32'h0);
        @(posedge clk_cog);
        @(posedge clk_cog);
        #1;
        res = 1'b0;

        $display("[TB] directed commands");
        applyStimulus(1'b1, SZ_LONG, 16'h0100, 32'hDEADBEEF, 1'b0, 1'b0, lat);
        applyStimulus(1'b0, SZ_LONG, 16'h0100, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("long_read_0100", host_rdata, 32'hDEADBEEF);
        applyStimulus(1'b1, SZ_LONG, 16'h0100, 32'h11223344, 1'b0, 1'b0, lat);
        applyStimulus(1'b0, SZ_BYTE, 16'h0103, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("byte_read_0103", host_rdata, 32'h00000011);
        applyStimulus(1'b1, SZ_LONG, 16'h0100, 32'hAABBCCDD, 1'b0, 1'b0, lat);
        applyStimulus(1'b0, SZ_WORD, 16'h0102, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("word_read_0102", host_rdata, 32'h0000AABB);
        applyStimulus(1'b0, SZ_LONG, 16'h0102, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("misaligned_latency", 32'(lat), 32'd1);
        applyStimulus(1'b1, 2'b11, 16'h0100, 32'h12345678, 1'b0, 1'b0, lat);
        applyStimulus(1'b1, SZ_BYTE, 16'hFFFF, 32'h000000A5, 1'b0, 1'b0, lat);
        applyStimulus(1'b0, SZ_BYTE, 16'hFFFF, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("byte_read_ffff", host_rdata, 32'h000000A5);

        $display("[TB] timeout");
        ack_on = 1'b0;
        applyStimulus(1'b0, SZ_WORD, 16'h0100, 32'h0, 1'b0, 1'b1, lat);
        checkOutput("timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
        ack_on = 1'b1;

        $display("[TB] reset during request");
        ack_on     = 1'b0;
        cur_we     = 1'b0;
        cur_size   = SZ_LONG;
        cur_addr   = 16'h0200;
        cur_d      = 32'h0;
        cur_bus_ok = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_size  = SZ_LONG;
        host_addr  = 16'h0200;
        host_wdata = 32'h0;
        @(posedge clk_cog);
        #1;
        host_req = 1'b0;
        n = 0;
        while (!bus_r && n < 40) begin
            @(posedge clk_cog);
            #1;
            n++;
        end
        checkOutput("reset_setup_bus_r", {31'b0, bus_r}, 32'h1);
        #2;
        res = 1'b1;
        #1;
        checkOutput("midreset_bus", {31'b0, |{bus_r, bus_w, bus_s, bus_a, bus_d}}, 32'h0);
        checkOutput("midreset_busy", {31'b0, host_busy}, 32'h0);
        checkOutput("midreset_done", {31'b0, host_done}, 32'h0);
        checkOutput("midreset_rdata", host_rdata, 32'h0);
        exp_q.delete();
        cur_bus_ok = 1'b0;
        last_rdata = 32'h0;
        @(posedge clk_cog);
        #1;
        res    = 1'b0;
        ack_on = 1'b1;
        applyStimulus(1'b0, SZ_LONG, 16'h0100, 32'h0, 1'b0, 1'b0, lat);
        checkOutput("post_reset_read", host_rdata, 32'hAABBCCDD);

        $display("[TB] random commands");
        for (int i = 0; i < 40; i++) begin
            sz = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
            a  = {($urandom_range(1) == 1) ? 12'h010 : 12'hFFF, 4'($urandom)};
            if ($urandom_range(3) != 0) begin
                if (sz == SZ_WORD) a[0] = 1'b0;
                if (sz == SZ_LONG) a[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom), sz, a, $urandom, 1'b1, 1'b0, lat);
        end

        repeat (4) @(posedge clk_cog);
        #1;
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
